regfile_wb_queue: RTL and testbench
===================================

// Module: regfile_wb_queue
// PURPOSE
//  Write-side master for the 3R/2W register file: collects writeback requests from the execute
//  and load units, buffers them in order in a small FIFO, and drains up to two per cycle onto
//  the register file's two write ports. Also reports to operand fetch whether a queued write
//  targets a given register, so that the read stage can stall.
// PARAMETERS
//  DATA_W  16  register data width
//  ADDR_W  6   register index width (64 registers)
//  DEPTH   4   FIFO entries; power of two, >= 2
// PORTS
//  clock           in   1       rising-edge clock
//  reset           in   1       asynchronous, active-high
//  ex_valid        in   1       execute unit writeback request
//  ex_ready        out  1       execute request accepted this cycle when ex_valid & ex_ready
//  ex_addr         in   ADDR_W  execute destination register
//  ex_data         in   DATA_W  execute result
//  ld_valid        in   1       load unit writeback request
//  ld_ready        out  1       load request accepted this cycle when ld_valid & ld_ready
//  ld_addr         in   ADDR_W  load destination register
//  ld_data         in   DATA_W  load data
//  wb_hold         in   1       1 = issue no writes this cycle (pipeline freeze)
//  reg_wr1         out  ADDR_W  write port 1 address (oldest entry)
//  reg_wr1_data    out  DATA_W  write port 1 data
//  reg_wr1_enable  out  1       write port 1 enable
//  reg_wr2         out  ADDR_W  write port 2 address (second-oldest entry)
//  reg_wr2_data    out  DATA_W  write port 2 data
//  reg_wr2_enable  out  1       write port 2 enable
//  hz_addr         in   ADDR_W  register queried by operand fetch
//  hz_hit          out  1       1 = a valid queued entry targets hz_addr (combinational)
//  count           out  $clog2(DEPTH)+1  occupied entries (registered)
// BEHAVIOUR
//  - Reset: FIFO pointers and count cleared; all enables 0; hz_hit 0; ex_ready 1; ld_ready 1.
//    Reset asserted mid-operation discards every queued entry; nothing is issued afterwards.
//  - free = DEPTH - count, taken from the registered count. Same-cycle drains do not free space.
//  - ex_ready = (free >= 1). ld_ready = (free >= 2) | (free == 1 & ~ex_valid).
//  - Enqueue order on simultaneous accept: ex entry first (older), then ld entry.
//  - Issue (combinational from FIFO head), with wb_hold = 0:
//      count >= 1 -> port 1 takes head: reg_wr1_enable = 1.
//      count >= 2 & addr[head+1] != addr[head] -> port 2 takes head+1: reg_wr2_enable = 1.
//      count >= 2 & addresses equal -> port 2 idle; head+1 issues next cycle (order kept).
//    wb_hold = 1 or count == 0 -> both enables 0. Addr/data outputs are don't-care when enable = 0.
//  - Dequeue at the clock edge: the number of entries dequeued equals the number of enables
//    asserted. Pointers wrap modulo DEPTH.
//  - count_next = count + accepted (0..2) - issued (0..2). Count never exceeds DEPTH.
//  - Latency: a request accepted at edge N is visible on a write port in cycle N+1 at the
//    earliest, and is written at edge N+1. There is no bypass from the inputs to the write ports.
//  - hz_hit: OR over occupied entries of (addr == hz_addr). Same-cycle inputs are excluded.
//    Entries issuing this cycle are still counted.
//  - Full (count == DEPTH): both readys are 0 even if a drain occurs that cycle.
//    Empty (count == 0): no issue, hz_hit = 0.
// TESTING
//  1. Reset with ex_valid=1, ex_addr=5, ex_data=16'h1234 -> after release, port 1 addr 5 data
//     16'h1234 enable 1 one cycle later; count returns to 0.
//  2. Same cycle ex(3,16'hAAAA) + ld(4,16'hBBBB) into empty FIFO -> next cycle wr1=3/AAAA,
//     wr2=4/BBBB, both enables 1; count 2->0.
//  3. ex(7,16'h0001) + ld(7,16'h0002) -> cycle 1: only wr1=7/0001; cycle 2: wr1=7/0002.
//     The final value of reg 7 is 16'h0002.
//  4. wb_hold=1 while 4 requests are pushed (DEPTH=4) -> count=4, ex_ready=ld_ready=0, enables 0.
//     Release hold -> 2 writes/cycle for 2 cycles, FIFO order preserved.
//  5. Queue reg 9, hz_addr=9 -> hz_hit=1 until the cycle after the write issues. hz_addr=10 -> 0.
//  6. count=3 with ex_valid=1 and ld_valid=1 -> ex accepted, ld_ready=0. With ex_valid=0 ->
//     ld accepted. Assert reset while 3 entries are queued -> enables 0, count 0, no writes issued.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// Writeback queue for the 3R/2W register file: buffers execute/load writebacks in order
// and drains up to two per cycle, with a hazard query for operand fetch.
module regfile_wb_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ex_valid,
  output logic                     ex_ready,
  input  logic [ADDR_W-1:0]        ex_addr,
  input  logic [DATA_W-1:0]        ex_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic                     wb_hold,
  output logic [ADDR_W-1:0]        reg_wr1,
  output logic [DATA_W-1:0]        reg_wr1_data,
  output logic                     reg_wr1_enable,
  output logic [ADDR_W-1:0]        reg_wr2,
  output logic [DATA_W-1:0]        reg_wr2_data,
  output logic                     reg_wr2_enable,
  input  logic [ADDR_W-1:0]        hz_addr,
  output logic                     hz_hit,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     head, tail, head1, ld_slot, offset;
  logic [CW-1:0]     free;
  logic              ex_acc, ld_acc;

  // Space is judged from the registered count only; a same-cycle drain never frees a slot.
  assign free     = CW'(DEPTH) - count;
  assign ex_ready = (free != '0);
  assign ld_ready = (free >= CW'(2)) | ((free == CW'(1)) & ~ex_valid);
  assign ex_acc   = ex_valid & ex_ready;
  assign ld_acc   = ld_valid & ld_ready;
  assign ld_slot  = tail + PW'(ex_acc);
  assign head1    = head + PW'(1);

  // Port 2 stays idle when the two oldest entries hit the same register, keeping write order.
  assign reg_wr1        = addr_q[head];
  assign reg_wr1_data   = data_q[head];
  assign reg_wr1_enable = ~wb_hold & (count != '0);
  assign reg_wr2        = addr_q[head1];
  assign reg_wr2_data   = data_q[head1];
  assign reg_wr2_enable = ~wb_hold & (count >= CW'(2)) & (addr_q[head1] != addr_q[head]);

  always_comb begin
    hz_hit = 1'b0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - head;
      if (({1'b0, offset} < count) && (addr_q[i] == hz_addr))
        hz_hit = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(reg_wr1_enable) + PW'(reg_wr2_enable);
      tail  <= tail + PW'(ex_acc) + PW'(ld_acc);
      count <= count + CW'(ex_acc) + CW'(ld_acc)
               - CW'(reg_wr1_enable) - CW'(reg_wr2_enable);
    end
  end

  // The ex entry lands first so it is older than a simultaneously accepted ld entry.
  always_ff @(posedge clock) begin
    if (ex_acc) begin
      addr_q[tail] <= ex_addr;
      data_q[tail] <= ex_data;
    end
    if (ld_acc) begin
      addr_q[ld_slot] <= ld_addr;
      data_q[ld_slot] <= ld_data;
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue with a small register-file model fed by the write ports.
module tb_regfile_wb_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ready, ld_valid, ld_ready, wb_hold;
  logic [5:0]  ex_addr, ld_addr, reg_wr1, reg_wr2, hz_addr;
  logic [15:0] ex_data, ld_data, reg_wr1_data, reg_wr2_data;
  logic        reg_wr1_enable, reg_wr2_enable, hz_hit;
  logic [2:0]  count;

  logic [15:0] rf [64];
  int          wr_count = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          wr_snap;

  regfile_wb_queue #(.DATA_W(16), .ADDR_W(6), .DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_data(ex_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .wb_hold(wb_hold),
    .reg_wr1(reg_wr1), .reg_wr1_data(reg_wr1_data), .reg_wr1_enable(reg_wr1_enable),
    .reg_wr2(reg_wr2), .reg_wr2_data(reg_wr2_data), .reg_wr2_enable(reg_wr2_enable),
    .hz_addr(hz_addr), .hz_hit(hz_hit), .count(count)
  );

  always #5 clock = ~clock;

  // Register file model: commits whatever the write ports present at each rising edge.
  always @(posedge clock) begin
    if (reg_wr1_enable) rf[reg_wr1] <= reg_wr1_data;
    if (reg_wr2_enable) rf[reg_wr2] <= reg_wr2_data;
    if (reg_wr1_enable) wr_count <= wr_count + 1 + int'(reg_wr2_enable);
    else if (reg_wr2_enable) wr_count <= wr_count + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic exv, input logic [5:0] exa, input logic [15:0] exd,
                               input logic ldv, input logic [5:0] lda, input logic [15:0] ldd,
                               input logic hold);
    ex_valid = exv; ex_addr = exa; ex_data = exd;
    ld_valid = ldv; ld_addr = lda; ld_data = ldd;
    wb_hold  = hold;
    #1;
  endtask

  task automatic idle(input logic hold);
    applyStimulus(1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 16'h0, hold);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkPorts(input string tag, input logic e1, input logic [5:0] a1,
                            input logic [15:0] d1, input logic e2, input logic [5:0] a2,
                            input logic [15:0] d2);
    checkOutput({tag, ".en1"}, 32'(reg_wr1_enable), 32'(e1));
    if (e1) begin
      checkOutput({tag, ".wr1"}, 32'(reg_wr1), 32'(a1));
      checkOutput({tag, ".wr1_data"}, 32'(reg_wr1_data), 32'(d1));
    end
    checkOutput({tag, ".en2"}, 32'(reg_wr2_enable), 32'(e2));
    if (e2) begin
      checkOutput({tag, ".wr2"}, 32'(reg_wr2), 32'(a2));
      checkOutput({tag, ".wr2_data"}, 32'(reg_wr2_data), 32'(d2));
    end
  endtask

  initial begin
    // Reset held while execute already requests a write.
    reset = 1'b1;
    hz_addr = 6'd5;
    applyStimulus(1'b1, 6'd5, 16'h1234, 1'b0, 6'd0, 16'h0, 1'b0);
    checkOutput("rst.count", 32'(count), 32'd0);
    checkPorts("rst", 1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 16'h0);
    checkOutput("rst.hz_hit", 32'(hz_hit), 32'd0);
    checkOutput("rst.ex_ready", 32'(ex_ready), 32'd1);
    checkOutput("rst.ld_ready", 32'(ld_ready), 32'd1);
    tick(); tick();
    reset = 1'b0;
    tick();
    idle(1'b0);
    checkOutput("t1.count", 32'(count), 32'd1);
    checkPorts("t1", 1'b1, 6'd5, 16'h1234, 1'b0, 6'd0, 16'h0);
    tick();
    checkOutput("t1.count_after", 32'(count), 32'd0);
    checkOutput("t1.rf5", 32'(rf[5]), 32'h1234);

    // Dual accept into empty queue, dual issue next cycle.
    applyStimulus(1'b1, 6'd3, 16'hAAAA, 1'b1, 6'd4, 16'hBBBB, 1'b0);
    checkOutput("t2.ex_ready", 32'(ex_ready), 32'd1);
    checkOutput("t2.ld_ready", 32'(ld_ready), 32'd1);
    checkPorts("t2.same_cycle", 1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 16'h0);
    tick();
    idle(1'b0);
    checkOutput("t2.count", 32'(count), 32'd2);
    checkPorts("t2", 1'b1, 6'd3, 16'hAAAA, 1'b1, 6'd4, 16'hBBBB);
    tick();
    checkOutput("t2.count_after", 32'(count), 32'd0);

    // Same destination: serialized, later write wins.
    applyStimulus(1'b1, 6'd7, 16'h0001, 1'b1, 6'd7, 16'h0002, 1'b0);
    tick();
    idle(1'b0);
    checkPorts("t3.c1", 1'b1, 6'd7, 16'h0001, 1'b0, 6'd0, 16'h0);
    tick();
    checkOutput("t3.count", 32'(count), 32'd1);
    checkPorts("t3.c2", 1'b1, 6'd7, 16'h0002, 1'b0, 6'd0, 16'h0);
    tick();
    checkOutput("t3.count_after", 32'(count), 32'd0);
    checkOutput("t3.rf7", 32'(rf[7]), 32'h0002);

    // Fill under hold, then drain two per cycle in order; full blocks even while draining.
    applyStimulus(1'b1, 6'd10, 16'h00A1, 1'b1, 6'd11, 16'h00A2, 1'b1);
    tick();
    applyStimulus(1'b1, 6'd12, 16'h00A3, 1'b1, 6'd13, 16'h00A4, 1'b1);
    checkOutput("t4.ld_ready_free2", 32'(ld_ready), 32'd1);
    tick();
    applyStimulus(1'b1, 6'd20, 16'hDEAD, 1'b1, 6'd21, 16'hBEEF, 1'b1);
    checkOutput("t4.count_full", 32'(count), 32'd4);
    checkOutput("t4.ex_ready_full", 32'(ex_ready), 32'd0);
    checkOutput("t4.ld_ready_full", 32'(ld_ready), 32'd0);
    checkPorts("t4.hold", 1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 16'h0);
    tick();
    applyStimulus(1'b1, 6'd20, 16'hDEAD, 1'b1, 6'd21, 16'hBEEF, 1'b0);
    checkOutput("t4.count_held", 32'(count), 32'd4);
    checkOutput("t4.ex_ready_drain", 32'(ex_ready), 32'd0);
    checkOutput("t4.ld_ready_drain", 32'(ld_ready), 32'd0);
    checkPorts("t4.d1", 1'b1, 6'd10, 16'h00A1, 1'b1, 6'd11, 16'h00A2);
    tick();
    idle(1'b0);
    checkOutput("t4.count_mid", 32'(count), 32'd2);
    checkPorts("t4.d2", 1'b1, 6'd12, 16'h00A3, 1'b1, 6'd13, 16'h00A4);
    tick();
    checkOutput("t4.count_after", 32'(count), 32'd0);
    checkOutput("t4.rf13", 32'(rf[13]), 32'h00A4);

    // Hazard query: inputs excluded, issuing entry still counted.
    hz_addr = 6'd9;
    applyStimulus(1'b1, 6'd9, 16'h0099, 1'b0, 6'd0, 16'h0, 1'b0);
    checkOutput("t5.hz_input", 32'(hz_hit), 32'd0);
    tick();
    idle(1'b0);
    checkOutput("t5.hz_issue", 32'(hz_hit), 32'd1);
    hz_addr = 6'd10; #1;
    checkOutput("t5.hz_other", 32'(hz_hit), 32'd0);
    hz_addr = 6'd9; #1;
    tick();
    checkOutput("t5.hz_after", 32'(hz_hit), 32'd0);

    // Ready arbitration at count 3.
    applyStimulus(1'b1, 6'd21, 16'h00D1, 1'b1, 6'd21, 16'h00D2, 1'b1);
    tick();
    applyStimulus(1'b1, 6'd22, 16'h00D3, 1'b0, 6'd0, 16'h0, 1'b1);
    tick();
    applyStimulus(1'b1, 6'd23, 16'h00D4, 1'b1, 6'd25, 16'h00D5, 1'b1);
    checkOutput("t6.count3", 32'(count), 32'd3);
    checkOutput("t6.ex_ready3", 32'(ex_ready), 32'd1);
    checkOutput("t6.ld_ready3_ex", 32'(ld_ready), 32'd0);
    hz_addr = 6'd22; #1;
    checkOutput("t6.hz_tail", 32'(hz_hit), 32'd1);
    tick();
    idle(1'b0);
    checkOutput("t6.count4", 32'(count), 32'd4);
    checkPorts("t6.eq", 1'b1, 6'd21, 16'h00D1, 1'b0, 6'd0, 16'h0);
    tick();
    applyStimulus(1'b0, 6'd0, 16'h0, 1'b1, 6'd24, 16'h00D6, 1'b1);
    checkOutput("t6.count3b", 32'(count), 32'd3);
    checkOutput("t6.ld_ready3_noex", 32'(ld_ready), 32'd1);
    tick();
    idle(1'b0);
    checkOutput("t6.count4b", 32'(count), 32'd4);
    checkPorts("t6.d1", 1'b1, 6'd21, 16'h00D2, 1'b1, 6'd22, 16'h00D3);
    tick();
    checkPorts("t6.d2", 1'b1, 6'd23, 16'h00D4, 1'b1, 6'd24, 16'h00D6);
    tick();
    checkOutput("t6.count_after", 32'(count), 32'd0);
    checkOutput("t6.rf21", 32'(rf[21]), 32'h00D2);

    // Reset with three entries queued discards them.
    applyStimulus(1'b1, 6'd50, 16'h00E1, 1'b1, 6'd51, 16'h00E2, 1'b1);
    tick();
    applyStimulus(1'b1, 6'd52, 16'h00E3, 1'b0, 6'd0, 16'h0, 1'b1);
    tick();
    idle(1'b1);
    hz_addr = 6'd51; #1;
    checkOutput("t7.count3", 32'(count), 32'd3);
    checkOutput("t7.hz_pre", 32'(hz_hit), 32'd1);
    wr_snap = wr_count;
    reset = 1'b1;
    idle(1'b0);
    checkOutput("t7.count_rst", 32'(count), 32'd0);
    checkPorts("t7.rst", 1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 16'h0);
    checkOutput("t7.hz_rst", 32'(hz_hit), 32'd0);
    tick();
    reset = 1'b0;
    tick(); tick();
    checkOutput("t7.count_post", 32'(count), 32'd0);
    checkPorts("t7.post", 1'b0, 6'd0, 16'h0, 1'b0, 6'd0, 16'h0);
    checkOutput("t7.no_writes", 32'(wr_count), 32'(wr_snap));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
